// File: rtl/ext_pkg.sv
// ---------------------------------------------------------------------------
// ext_pkg
// Shared definitions for the immediate-extension pipeline.
//   ext_op_e      : extension modes carried on the 2-bit EOp field
//   occ_state_e   : occupancy states of the 2-entry result buffer
//   EXT_OUT_MARGIN: headroom OUT_W needs above IMM_W (the shift-by-2 mode
//                   discards two sign bits, so two spare bits must exist)
//   extWidthsLegal: true when an IMM_W/OUT_W pair is usable
// ---------------------------------------------------------------------------
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN     = 2'd0,
        EXT_ZERO     = 2'd1,
        EXT_LUI      = 2'd2,
        EXT_SIGN_SL2 = 2'd3
    } ext_op_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    localparam int EXT_OUT_MARGIN = 2;

    function automatic bit extWidthsLegal(input int immW, input int outW);
        return outW >= immW + EXT_OUT_MARGIN;
    endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// ---------------------------------------------------------------------------
// ext_pipe_if
// Valid/ready bundle between an operand producer and a result consumer,
// with the extension pipeline sitting in between.
//   in_valid/in_ready   : operand handshake (imm, EOp)
//   out_valid/out_ready : result handshake (ext)
//   cnt                 : saturating count of delivered results
// modport master : the testbench / upstream+downstream environment
// modport slave  : the ext_pipe block itself
// ---------------------------------------------------------------------------
interface ext_pipe_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IMM_W-1:0] imm;
    logic [1:0]       EOp;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] ext;
    logic [CNT_W-1:0] cnt;

    modport master (
        output in_valid, imm, EOp, out_ready,
        input  in_ready, out_valid, ext, cnt
    );

    modport slave (
        input  in_valid, imm, EOp, out_ready,
        output in_ready, out_valid, ext, cnt
    );
endinterface

// File: rtl/ext_core.sv
// ---------------------------------------------------------------------------
// ext_core
// Purely combinational immediate extender.
//   imm_i    : IMM_W-bit immediate
//   eop_i    : extension mode (ext_op_e encoding)
//   result_o : OUT_W-bit extended value
// ---------------------------------------------------------------------------
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic [IMM_W-1:0] imm_i,
    input  logic [1:0]       eop_i,
    output logic [OUT_W-1:0] result_o
);

    logic [OUT_W-1:0] signExt;

    // The shift-by-2 mode is built from the sign-extended value, so it is
    // computed once and shared.
    assign signExt = {{(OUT_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

    // Select the extension flavour; the shifted mode drops the top two
    // sign bits and zero-fills the bottom two.
    always_comb begin
        result_o = '0;
        case (ext_op_e'(eop_i))
            EXT_SIGN:     result_o = signExt;
            EXT_ZERO:     result_o = {{(OUT_W-IMM_W){1'b0}}, imm_i};
            EXT_LUI:      result_o = {imm_i, {(OUT_W-IMM_W){1'b0}}};
            EXT_SIGN_SL2: result_o = {signExt[OUT_W-3:0], 2'b00};
            default:      result_o = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ---------------------------------------------------------------------------
// ext_pipe
// Immediate extender followed by a 2-entry in-order result buffer.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; empties the buffer, clears ext/cnt
//   bus   : ext_pipe_if slave modport
//           in_valid/in_ready/imm/EOp  - operand side
//           out_valid/out_ready/ext    - result side (ext = oldest entry)
//           cnt                        - saturating delivered-result count
// in_ready depends only on registered occupancy, never on out_ready, so a
// full buffer refuses operands even in a cycle where it also drains.
// ---------------------------------------------------------------------------
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        reset,
    ext_pipe_if.slave  bus
);

    if (!extWidthsLegal(IMM_W, OUT_W)) begin : gBadWidths
        $error("ext_pipe: OUT_W must be at least IMM_W+2");
    end

    logic [OUT_W-1:0] coreResult;

    occ_state_e       state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic inReady;
    logic outValid;
    logic push;
    logic pop;

    ext_core #(
        .IMM_W (IMM_W),
        .OUT_W (OUT_W)
    ) uCore (
        .imm_i    (bus.imm),
        .eop_i    (bus.EOp),
        .result_o (coreResult)
    );

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (push)          state_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)         state_d = OCC_FULL;
                else if (pop && !push)    state_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop)           state_d = OCC_ONE;
            default:                      state_d = OCC_EMPTY;
        endcase
    end

    // Handshake outputs decoded from occupancy alone.
    always_comb begin
        inReady  = (state_q != OCC_FULL);
        outValid = (state_q != OCC_EMPTY);
        push     = bus.in_valid && inReady;
        pop      = outValid && bus.out_ready;
    end

    // Buffer data movement. head is always the oldest entry and is simply
    // left alone when the last entry pops, which keeps ext at its last value
    // while empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        case (state_q)
            OCC_EMPTY: if (push) head_d = coreResult;
            OCC_ONE: begin
                if (push && pop) head_d = coreResult;
                else if (push)   tail_d = coreResult;
            end
            OCC_FULL:  if (pop)  head_d = tail_q;
            default: begin
                head_d = head_q;
                tail_d = tail_q;
            end
        endcase
    end

    // Delivered-result counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (pop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.ext       = head_q;
    assign bus.cnt       = cnt_q;

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 The block SHALL have parameter IMM_W, default 16, giving the immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, giving the extended result width; legal only when OUT_W >= IMM_W+2.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the delivered-result counter width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the upstream side presents an operand.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand this cycle.
REQ-008 The block SHALL have port imm, input, IMM_W bits, the immediate operand.
REQ-009 The block SHALL have port EOp, input, 2 bits, the extension mode.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the head result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the downstream side consumes the result.
REQ-012 The block SHALL have port ext, output, OUT_W bits, the head result.
REQ-013 The block SHALL have port cnt, output, CNT_W bits, the number of delivered results.

Function
REQ-014 EOp=0 SHALL sign-extend imm to OUT_W bits.
REQ-015 EOp=1 SHALL zero-extend imm to OUT_W bits.
REQ-016 EOp=2 SHALL place imm in the upper IMM_W bits of the result, with the lower OUT_W-IMM_W bits zero.
REQ-017 EOp=3 SHALL sign-extend imm and shift it left by 2, discarding the top 2 bits and zero-filling the bottom 2 bits.
REQ-018 An operand SHALL be accepted on a rising clk edge with in_valid=1 and in_ready=1; imm and EOp are sampled only at that edge.
REQ-019 Accepted results SHALL enter a 2-entry in-order buffer with occupancy 0, 1 or 2.
REQ-020 in_ready SHALL equal (occupancy<2) and SHALL be registered-state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (occupancy>0); ext SHALL present the oldest entry.
REQ-022 Latency SHALL be 1 cycle: an operand accepted at edge N appears on ext with out_valid=1 after edge N when the buffer was empty.
REQ-023 With out_ready held at 1, the block SHALL sustain 1 result per cycle.
REQ-024 Pop SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-026 When full (occupancy=2), no push SHALL occur even if out_ready=1 in that cycle.
REQ-027 While out_valid=1 and out_ready=0, ext SHALL hold stable.
REQ-028 When empty, ext SHALL hold its last value, and out_ready SHALL be ignored.
REQ-029 cnt SHALL increment by 1 on each pop.
REQ-030 cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-031 Asserting reset SHALL immediately force occupancy to 0, out_valid=0, in_ready=1, ext=0 and cnt=0, including mid-stream; buffered results are discarded.
REQ-032 After reset deasserts, the first rising clk edge SHALL be able to accept an operand.

Structure
REQ-033 EOp encodings (EXT_SIGN=0, EXT_ZERO=1, EXT_LUI=2, EXT_SIGN_SL2=3) SHALL be defined in shared package ext_pkg, together with the OUT_W>=IMM_W+2 legality check constant.
REQ-034 Combinational extension SHALL live in sub-module ext_core (imm, EOp -> result), instantiated once ahead of the buffer.

Verification
REQ-035 Defaults, imm=16'h8000, EOp 0/1/2/3 in four back-to-back pushes with out_ready=1 SHALL yield ext=32'hFFFF8000, 32'h00008000, 32'h80000000, 32'hFFFE0000 on consecutive cycles; final cnt=4.
REQ-036 Defaults, imm=16'h7FFF with EOp=0 SHALL yield 32'h00007FFF, and with EOp=3 SHALL yield 32'h0001FFFC.
REQ-037 With out_ready=0, three pushes (values A, B, C) SHALL drop in_ready to 0 after B, leave C unaccepted, hold ext=A, and then, with out_ready=1, SHALL deliver A then B in order.
REQ-038 With CNT_W=2, six pops SHALL give cnt sequence 1, 2, 3, 3, 3, 3.
REQ-039 Asserting reset between clk edges with occupancy=2 SHALL immediately give out_valid=0, in_ready=1, cnt=0, and no stale result SHALL appear afterward.
REQ-040 With IMM_W=8 and OUT_W=16, imm=8'h80 with EOp 0/1/2/3 SHALL yield 16'hFF80, 16'h0080, 16'h8000, 16'hFE00.
